// File: rtl/fifo_rd_sequencer.sv
// fifo_rd_sequencer: read-side controller for a DO_REG=1, non-FWFT dual-clock FIFO (rd_clk domain)
//   clk, rst_n        read clock, asynchronous active-low reset
//   flush             1-cycle pulse: discard buffered data and re-run the FIFO reset sequence
//   fifo_rst          FIFO reset, held high for RST_CYCLES, followed by RCV_CYCLES of recovery
//   fifo_rd_en        credit-limited read strobe, issued only in RUN
//   fifo_empty        FIFO empty flag
//   fifo_dout         FIFO read data, valid RD_LATENCY cycles after fifo_rd_en
//   m_data, m_valid   output stream, presented from the skid buffer
//   m_ready           output stream backpressure
//   init_done         high while in RUN
//   level             skid buffer occupancy
module fifo_rd_sequencer #(
  parameter int WIDTH      = 32,
  parameter int RD_LATENCY = 2,
  parameter int SKID_DEPTH = 4,
  parameter int RST_CYCLES = 5,
  parameter int RCV_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  output logic                          fifo_rst,
  output logic                          fifo_rd_en,
  input  logic                          fifo_empty,
  input  logic [WIDTH-1:0]              fifo_dout,
  output logic [WIDTH-1:0]              m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          init_done,
  output logic [$clog2(SKID_DEPTH):0]   level
);
  localparam int AW   = $clog2(SKID_DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = RST_CYCLES > RCV_CYCLES ? RST_CYCLES : RCV_CYCLES;
  localparam int CW   = $clog2(CMAX);
  typedef enum logic [1:0] {RST_ASSERT, RST_RECOVER, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [RD_LATENCY-1:0] sr;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic [LW:0] inflight, credit;
  logic run, push, pop, clear;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RST_ASSERT;
    else state <= state_nx;
  always_comb
    state_nx = flush ? RST_ASSERT :
               state == RST_ASSERT  ? (cnt == CW'(RST_CYCLES - 1) ? RST_RECOVER : RST_ASSERT) :
               state == RST_RECOVER ? (cnt == CW'(RCV_CYCLES - 1) ? RUN : RST_RECOVER) : RUN;
  always_comb begin
    run       = state == RUN;
    fifo_rst  = state == RST_ASSERT;
    init_done = run;
  end
  // Counter restarts on every state change and on flush, so a flush during reset restarts the window.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state_nx != state || flush || run) ? '0 : cnt + CW'(1);
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + (LW + 1)'(sr[i]);
  end
  // Credits count words in flight plus words left after this cycle's pop; the exiting bit is
  // still in flight here and lands in level next cycle, so it is counted exactly once.
  always_comb begin
    push       = sr[RD_LATENCY-1];
    pop        = m_valid && m_ready;
    clear      = flush || !run;
    credit     = inflight + (LW + 1)'(level - LW'(pop));
    fifo_rd_en = run && !fifo_empty && credit < (LW + 1)'(SKID_DEPTH);
    m_valid    = level != '0;
    m_data     = m_valid ? mem[rd_ptr] : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      sr     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      sr     <= RD_LATENCY'({sr, fifo_rd_en});
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      level  <= level + LW'(push) - LW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= fifo_dout;
  assert property (@(posedge clk) disable iff (!rst_n) !(push && level == LW'(SKID_DEPTH)));
endmodule

// File: tb/tb_fifo_rd_sequencer.sv
// tb_fifo_rd_sequencer: directed/random bench with a queue-based FIFO model and output scoreboard
module tb_fifo_rd_sequencer;
  localparam int W = 32;
  localparam int L = 2;
  logic clk = 0, rst_n = 0, flush = 0, m_ready = 0;
  logic fifo_rst, fifo_rd_en, fifo_empty, m_valid, init_done;
  logic [W-1:0] fifo_dout, m_data;
  logic [2:0] level;
  int checks = 0, fails = 0, got = 0, issued = 0;
  int wr_idx = 0, rd_idx = 0;
  logic [W-1:0] fmem [4096];
  logic [W-1:0] pipe [L];
  logic [W-1:0] exp_q [$];

  fifo_rd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fifo_rst(fifo_rst), .fifo_rd_en(fifo_rd_en),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .init_done(init_done), .level(level)
  );

  always #5 clk = ~clk;

  assign fifo_empty = rd_idx == wr_idx;
  assign fifo_dout  = pipe[L-1];

  // FIFO model: read data appears L cycles after the read; reset drops its contents.
  // exp_q holds every word read that must reach the stream; flush/reset discard it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      rd_idx <= wr_idx;
    end else begin
      for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= (fifo_rd_en && !fifo_empty) ? fmem[rd_idx % 4096] : 32'hBAD0_0000;
      if (fifo_rst) rd_idx <= wr_idx;
      else if (fifo_rd_en && !fifo_empty) begin
        exp_q.push_back(fmem[rd_idx % 4096]);
        rd_idx <= rd_idx + 1;
      end
      if (flush) exp_q.delete();
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    check("rd_en_safe", fifo_rd_en && (fifo_rst || !init_done), 0);
    check("level_max", level <= 3'd4, 1);
    if (fifo_rd_en) issued++;
    if (m_valid && m_ready) begin
      check("exp_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("m_data", m_data, exp_q.pop_front());
      got++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [W-1:0] w);
    fmem[wr_idx % 4096] = w;
    wr_idx++;
  endtask

  task automatic wait_got(input int n, input int bound, input string tag);
    int k = 0;
    while (got < n && k < bound) begin
      cyc(1);
      k++;
    end
    check(tag, got, n);
  endtask

  task automatic seq_check(input string tag);
    int n = 0;
    @(negedge clk);
    while (fifo_rst && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_rst_len"}, n, 5);
    n = 0;
    while (!fifo_rst && !init_done && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_rcv_len"}, n, 8);
    check({tag, "_init_done"}, init_done, 1);
    cyc(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fifo_rst"}, fifo_rst, 1);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_level"}, level, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, k, run_len;
    // 1: reset window with an empty FIFO
    cyc(3);
    check_reset_outputs("t1_reset");
    rst_n = 1;
    seq_check("t1");
    check("t1_no_reads", issued, 0);
    // 2: 16 words, full-rate streaming
    m_ready = 1;
    g0 = got;
    for (int i = 1; i <= 16; i++) write_word(W'(i));
    k = 0;
    @(negedge clk);
    while (!m_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t2_valid_seen", m_valid, 1);
    run_len = 0;
    repeat (16) begin
      if (m_valid) run_len++;
      @(negedge clk);
    end
    check("t2_no_bubble", run_len, 16);
    cyc(2);
    check("t2_count", got - g0, 16);
    check("t2_drained", exp_q.size(), 0);
    // 3: backpressure stops reads at 4 credits, head holds steady
    m_ready = 0;
    issued = 0;
    g0 = got;
    for (int i = 1; i <= 16; i++) write_word(32'h100 + W'(i));
    cyc(20);
    check("t3_level", level, 4);
    check("t3_credits", issued, 4);
    check("t3_valid", m_valid, 1);
    check("t3_head", m_data, 32'h101);
    cyc(3);
    check("t3_stable", m_data, 32'h101);
    m_ready = 1;
    wait_got(g0 + 16, 100, "t3_all");
    cyc(2);
    check("t3_fifo_empty", fifo_empty, 1);
    check("t3_level_end", level, 0);
    // 4: 100 random words with m_ready toggling every cycle
    g0 = got;
    for (int i = 0; i < 100; i++) write_word($urandom);
    k = 0;
    while (got < g0 + 100 && k < 1000) begin
      m_ready = ~m_ready;
      cyc(1);
      k++;
    end
    check("t4_count", got - g0, 100);
    m_ready = 0;
    cyc(3);
    check("t4_level_end", level, 0);
    // 5: flush with reads in flight and a partly filled skid
    g0 = got;
    for (int i = 0; i < 10; i++) write_word(32'h5000 + W'(i));
    k = 0;
    while (level != 3'd2 && k < 30) begin
      cyc(1);
      k++;
    end
    check("t5_level_pre", level, 2);
    flush = 1;
    cyc(1);
    flush = 0;
    check("t5_valid_cleared", m_valid, 0);
    check("t5_level_cleared", level, 0);
    check("t5_fifo_rst", fifo_rst, 1);
    seq_check("t5");
    m_ready = 1;
    cyc(10);
    check("t5_nothing_late", got - g0, 0);
    check("t5_fifo_reset", fifo_empty, 1);
    for (int i = 0; i < 5; i++) write_word(32'h6000 + W'(i));
    wait_got(g0 + 5, 50, "t5_after");
    // 6: async reset mid-stream
    for (int i = 0; i < 20; i++) write_word(32'h7000 + W'(i));
    cyc(8);
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk);
    #1;
    rst_n = 1;
    seq_check("t6");
    g0 = got;
    for (int i = 0; i < 4; i++) write_word(32'h8000 + W'(i));
    wait_got(g0 + 4, 50, "t6_after");
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
